// File: rtl/bpu_pkg.sv
// rtl/bpu_pkg.sv - shared types, counter constants and PC index hash for the PHT.
package bpu_pkg;

  typedef logic [1:0] pht_cnt_t;

  localparam pht_cnt_t CNT_WNT = 2'b01;
  localparam pht_cnt_t CNT_MAX = 2'b11;

  typedef enum logic {INIT, RUN} pht_state_e;

  // Folds the 30 word-address bits of a PC into a 14-bit table index.
  function automatic logic [13:0] pht_hash(input logic [29:0] d);
    logic [13:0] idx;
    idx[13] = d[0] ^ d[29] ^ d[28];
    idx[12] = d[1] ^ d[27] ^ d[26];
    for (int i = 2; i < 14; i++) begin
      idx[13-i] = d[i] ^ d[27-i];
    end
    return idx;
  endfunction

endpackage

// File: rtl/pht_upd_fifo.sv
// rtl/pht_upd_fifo.sv - synchronous FIFO holding resolved-branch updates {idx, taken}.
module pht_upd_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int WIDTH      = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [WIDTH-1:0] slot_q [FIFO_DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             push_ok, pop_ok;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = slot_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(push_ok);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) slot_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/pht_update_engine.sv
// rtl/pht_update_engine.sv - 2-bit counter PHT with fetch lookup and queued read-modify-write updates.
// Define PHT_QUERY_FWD_EN to forward a same-cycle update write to a colliding lookup.
module pht_update_engine
  import bpu_pkg::*;
#(
  parameter int DATA_width = 30,
  parameter int HASH_width = 14,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        q_req,
  input  logic [31:0] q_pc,
  output logic        q_valid,
  output logic        q_taken,
  output logic [1:0]  q_cnt,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  output logic        init_done
);

  localparam int TBL = 1 << HASH_width;

  pht_cnt_t                pht_mem [TBL];
  pht_state_e              state_q, state_d;
  logic [HASH_width-1:0]   init_idx_q, init_idx_d;
  logic                    q_valid_q, q_valid_d;
  pht_cnt_t                rd_cnt_q, rd_cnt_d;
  logic                    s2_valid_q, s2_valid_d;
  logic [HASH_width-1:0]   s2_idx_q, s2_idx_d;
  logic                    s2_taken_q, s2_taken_d;

  logic                    run;
  logic [HASH_width-1:0]   q_idx, upd_idx, raddr, waddr;
  logic                    mem_we, fwd_hit, fwd_use;
  pht_cnt_t                wdata, s2_new;
  logic                    fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [HASH_width:0]     fifo_head;
  logic                    unused_pc_bits;

  assign unused_pc_bits = ^{q_pc[1:0], upd_pc[1:0]};

  assign run       = (state_q == RUN);
  assign q_idx     = pht_hash(q_pc[DATA_width+1:2]);
  assign upd_idx   = pht_hash(upd_pc[DATA_width+1:2]);
  assign upd_ready = run && !fifo_full;
  assign fifo_push = upd_valid && upd_ready;
  // Lookups own the shared read port; a pending update waits a cycle.
  assign fifo_pop  = run && !q_req && !fifo_empty;

  pht_upd_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (HASH_width + 1)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data ({upd_idx, upd_taken}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    if (s2_taken_q) s2_new = (rd_cnt_q == CNT_MAX) ? CNT_MAX : rd_cnt_q + 2'd1;
    else            s2_new = (rd_cnt_q == 2'b00)   ? 2'b00   : rd_cnt_q - 2'd1;
  end

  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    mem_we     = 1'b0;
    waddr      = s2_idx_q;
    wdata      = s2_new;
    raddr      = q_req ? q_idx : fifo_head[HASH_width:1];
    q_valid_d  = run && q_req;
    s2_valid_d = fifo_pop;
    s2_idx_d   = fifo_head[HASH_width:1];
    s2_taken_d = fifo_head[0];

    case (state_q)
      INIT: begin
        mem_we     = 1'b1;
        waddr      = init_idx_q;
        wdata      = CNT_WNT;
        init_idx_d = init_idx_q + HASH_width'(1);
        if (init_idx_q == '1) state_d = RUN;
      end
      RUN: mem_we = s2_valid_q;
      default: state_d = INIT;
    endcase

    // Update reads always see the in-flight write so consecutive updates to one index accumulate.
    fwd_hit = mem_we && (waddr == raddr);
`ifdef PHT_QUERY_FWD_EN
    fwd_use = fwd_hit;
`else
    fwd_use = fwd_hit && !q_req;
`endif
    rd_cnt_d = fwd_use ? wdata : pht_mem[raddr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= INIT;
      init_idx_q <= '0;
      q_valid_q  <= 1'b0;
      rd_cnt_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_idx_q   <= '0;
      s2_taken_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
      q_valid_q  <= q_valid_d;
      rd_cnt_q   <= rd_cnt_d;
      s2_valid_q <= s2_valid_d;
      s2_idx_q   <= s2_idx_d;
      s2_taken_q <= s2_taken_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) pht_mem[waddr] <= wdata;
  end

  assign q_valid   = q_valid_q;
  assign q_cnt     = q_valid_q ? rd_cnt_q : 2'b00;
  assign q_taken   = q_cnt[1];
  assign init_done = run;

endmodule
